// File: rtl/regfile_bist_ctrl.sv
// Self-test controller and port multiplexer for the 32x32 2R1W register file.
// Idle: CPU functional ports pass straight through. On Start the controller
// takes the register file over, writes three data patterns (one per pass)
// and reads every address back on both read ports, then reports pass/fail
// together with the first failing location.
module regfile_bist_ctrl #(
    parameter logic [31:0] PAT_A = 32'hAAAAAAAA,
    parameter logic [31:0] PAT_B = 32'h55555555
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    output logic        Busy,
    output logic        Done,
    output logic        Pass,
    output logic [4:0]  FailAddr,
    output logic        FailPort,
    output logic [1:0]  FailPattern,
    input  logic [31:0] FnWriteData,
    input  logic [4:0]  FnReadRegister1,
    input  logic [4:0]  FnReadRegister2,
    input  logic [4:0]  FnWriteRegister,
    input  logic        FnRegWrite,
    output logic [31:0] FnReadData1,
    output logic [31:0] FnReadData2,
    output logic [31:0] RfWriteData,
    output logic [4:0]  RfReadRegister1,
    output logic [4:0]  RfReadRegister2,
    output logic [4:0]  RfWriteRegister,
    output logic        RfRegWrite,
    input  logic [31:0] RfReadData1,
    input  logic [31:0] RfReadData2
);

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StRead,
        StDone
    } state_e;

    localparam logic [4:0] LastAddr = 5'd31;
    localparam logic [1:0] LastPat  = 2'd2;

    state_e      state_q, state_d;
    logic [4:0]  addr_q, addr_d;
    logic [1:0]  pat_q, pat_d;
    logic        pass_q, pass_d;
    logic [4:0]  fail_addr_q, fail_addr_d;
    logic        fail_port_q, fail_port_d;
    logic [1:0]  fail_pat_q, fail_pat_d;

    // BIST-side drive of the register file ports
    logic        bist_we;
    logic [4:0]  bist_wa;
    logic [31:0] bist_wd;
    logic [4:0]  bist_ra1;
    logic [4:0]  bist_ra2;

    logic [31:0] exp1;
    logic [31:0] exp2;
    logic        mism1;
    logic        mism2;

    // Pattern written to address a during pass p. Pattern 2 replicates the
    // address so that decoder aliasing shows up as a data mismatch.
    function automatic logic [31:0] pattern_data(input logic [1:0] p, input logic [4:0] a);
        logic [31:0] d;
        case (p)
            2'd0:    d = PAT_A;
            2'd1:    d = PAT_B;
            default: d = {a, a, a, a, a, a, a[1:0]};
        endcase
        return d;
    endfunction

    // Register 0 is hardwired to zero, so it must read back zero regardless
    // of what was written.
    function automatic logic [31:0] expected_data(input logic [1:0] p, input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : pattern_data(p, a);
    endfunction

    assign Busy        = (state_q == StWrite) || (state_q == StRead);
    assign Done        = (state_q == StDone);
    assign Pass        = pass_q;
    assign FailAddr    = fail_addr_q;
    assign FailPort    = fail_port_q;
    assign FailPattern = fail_pat_q;

    assign FnReadData1 = RfReadData1;
    assign FnReadData2 = RfReadData2;

    // BIST port drive, decoded from the current phase
    always_comb begin
        bist_we  = 1'b0;
        bist_wa  = 5'd0;
        bist_wd  = 32'd0;
        bist_ra1 = 5'd0;
        bist_ra2 = 5'd0;
        case (state_q)
            StWrite: begin
                bist_we = 1'b1;
                bist_wa = addr_q;
                bist_wd = pattern_data(pat_q, addr_q);
            end
            StRead: begin
                // Port 2 walks the addresses in reverse so each port sees every
                // address and the two ports never sit on the same location.
                bist_ra1 = addr_q;
                bist_ra2 = ~addr_q;
            end
            default: ;
        endcase
    end

    // Register file port mux; Busy alone selects so a reset hands the ports
    // back to the CPU without waiting for a clock.
    always_comb begin
        if (Busy) begin
            RfRegWrite      = bist_we;
            RfWriteRegister = bist_wa;
            RfWriteData     = bist_wd;
            RfReadRegister1 = bist_ra1;
            RfReadRegister2 = bist_ra2;
        end else begin
            RfRegWrite      = FnRegWrite;
            RfWriteRegister = FnWriteRegister;
            RfWriteData     = FnWriteData;
            RfReadRegister1 = FnReadRegister1;
            RfReadRegister2 = FnReadRegister2;
        end
    end

    // Read-back comparison against the expected value for both ports
    always_comb begin
        exp1  = expected_data(pat_q, addr_q);
        exp2  = expected_data(pat_q, ~addr_q);
        mism1 = (RfReadData1 != exp1);
        mism2 = (RfReadData2 != exp2);
    end

    // Next-state logic: phase sequencing and first-failure capture
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pat_d       = pat_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_port_d = fail_port_q;
        fail_pat_d  = fail_pat_q;
        case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d     = StWrite;
                    addr_d      = 5'd0;
                    pat_d       = 2'd0;
                    pass_d      = 1'b1;
                    fail_addr_d = 5'd0;
                    fail_port_d = 1'b0;
                    fail_pat_d  = 2'd0;
                end
            end
            StWrite: begin
                // Wraps 31 -> 0 exactly as the phase changes to read
                addr_d = addr_q + 5'd1;
                if (addr_q == LastAddr) begin
                    state_d = StRead;
                end
            end
            StRead: begin
                // pass_q doubles as "no failure recorded yet"; port 1 wins ties
                if (pass_q && (mism1 || mism2)) begin
                    pass_d      = 1'b0;
                    fail_pat_d  = pat_q;
                    fail_port_d = !mism1;
                    fail_addr_d = mism1 ? addr_q : ~addr_q;
                end
                addr_d = addr_q + 5'd1;
                if (addr_q == LastAddr) begin
                    if (pat_q == LastPat) begin
                        state_d = StDone;
                    end else begin
                        pat_d   = pat_q + 2'd1;
                        state_d = StWrite;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers, asynchronously cleared
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            addr_q      <= 5'd0;
            pat_q       <= 2'd0;
            pass_q      <= 1'b0;
            fail_addr_q <= 5'd0;
            fail_port_q <= 1'b0;
            fail_pat_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pat_q       <= pat_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_port_q <= fail_port_d;
            fail_pat_q  <= fail_pat_d;
        end
    end

endmodule

// File: tb/tb_regfile_bist_ctrl.sv
// Bench for regfile_bist_ctrl: a behavioural register file with selectable
// faults, a result scoreboard popped on Done, and a cycle-by-cycle check of
// the port sequence the controller drives.
module tb_regfile_bist_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Busy, Done, Pass, FailPort;
    logic [4:0]  FailAddr;
    logic [1:0]  FailPattern;
    logic [31:0] FnWriteData;
    logic [4:0]  FnReadRegister1, FnReadRegister2, FnWriteRegister;
    logic        FnRegWrite;
    logic [31:0] FnReadData1, FnReadData2;
    logic [31:0] RfWriteData;
    logic [4:0]  RfReadRegister1, RfReadRegister2, RfWriteRegister;
    logic        RfRegWrite;
    logic [31:0] RfReadData1, RfReadData2;

    typedef struct {
        logic       pass;
        logic [4:0] addr;
        logic       port;
        logic [1:0] pat;
    } res_t;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    // 0 ideal, 1 reg0 is a real register, 2 port 2 stuck on reg 17,
    // 3 every write lands in all registers 1..31
    int   fault    = 0;

    logic [31:0] regs [32];

    always #5 Clk = ~Clk;

    regfile_bist_ctrl dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Start           (Start),
        .Busy            (Busy),
        .Done            (Done),
        .Pass            (Pass),
        .FailAddr        (FailAddr),
        .FailPort        (FailPort),
        .FailPattern     (FailPattern),
        .FnWriteData     (FnWriteData),
        .FnReadRegister1 (FnReadRegister1),
        .FnReadRegister2 (FnReadRegister2),
        .FnWriteRegister (FnWriteRegister),
        .FnRegWrite      (FnRegWrite),
        .FnReadData1     (FnReadData1),
        .FnReadData2     (FnReadData2),
        .RfWriteData     (RfWriteData),
        .RfReadRegister1 (RfReadRegister1),
        .RfReadRegister2 (RfReadRegister2),
        .RfWriteRegister (RfWriteRegister),
        .RfRegWrite      (RfRegWrite),
        .RfReadData1     (RfReadData1),
        .RfReadData2     (RfReadData2)
    );

    // Register file model
    always @(posedge Clk) begin
        if (RfRegWrite) begin
            if (fault == 3) begin
                for (int i = 1; i < 32; i++) regs[i] <= RfWriteData;
            end else if (RfWriteRegister != 5'd0 || fault == 1) begin
                regs[RfWriteRegister] <= RfWriteData;
            end
        end
    end

    assign RfReadData1 = (RfReadRegister1 == 5'd0 && fault != 1) ? 32'd0 : regs[RfReadRegister1];
    assign RfReadData2 = (fault == 2) ? regs[17] :
                         (RfReadRegister2 == 5'd0 && fault != 1) ? 32'd0 : regs[RfReadRegister2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic logic [31:0] dpat(input int p, input int a);
        logic [4:0]  av;
        logic [31:0] v;
        av = 5'(a);
        v  = 32'd0;
        if (p == 0) v = 32'hAAAAAAAA;
        else if (p == 1) v = 32'h55555555;
        else begin
            for (int i = 0; i < 6; i++) v[31 - 5 * i -: 5] = av;
            v[1:0] = av[1:0];
        end
        return v;
    endfunction

    // Scoreboard monitor: every Done pulse retires one expected result
    always @(negedge Clk) begin
        if (!Reset && Done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("pass", {31'd0, Pass}, {31'd0, e.pass});
                check("fail_addr", {27'd0, FailAddr}, {27'd0, e.addr});
                check("fail_port", {31'd0, FailPort}, {31'd0, e.port});
                check("fail_pattern", {30'd0, FailPattern}, {30'd0, e.pat});
            end
        end
    end

    // Start a test and verify the full 194-cycle port sequence
    task automatic run_bist(input int fmode, input res_t e, input bit poke_start);
        int errs;
        int first_bad;
        fault = fmode;
        exp_q.push_back(e);
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        errs = 0;
        first_bad = -1;
        for (int c = 0; c < 194; c++) begin
            bit bad;
            bad = 1'b0;
            if (c < 192) begin
                int ph;
                int p;
                ph = c % 64;
                p  = c / 64;
                if (!Busy || Done) bad = 1'b1;
                if (ph < 32) begin
                    if (!RfRegWrite || RfWriteRegister != 5'(ph) || RfWriteData != dpat(p, ph))
                        bad = 1'b1;
                end else begin
                    if (RfRegWrite || RfReadRegister1 != 5'(ph - 32) ||
                        RfReadRegister2 != 5'(63 - ph))
                        bad = 1'b1;
                end
            end else if (c == 192) begin
                if (Busy || !Done) bad = 1'b1;
            end else begin
                if (Busy || Done) bad = 1'b1;
            end
            if (bad) begin
                if (errs == 0) first_bad = c;
                errs++;
            end
            Start = (poke_start && c == 100) ? 1'b1 : 1'b0;
            @(negedge Clk);
        end
        Start = 1'b0;
        n_checks++;
        if (errs == 0) n_pass++;
        else $display("FAIL bist_seq: %0d deviations, first at cycle %0d, want 0", errs, first_bad);
        check("done_seen", exp_q.size(), 32'd0);
    endtask

    initial begin
        res_t r;
        Reset           = 1'b0;
        Start           = 1'b0;
        FnWriteData     = 32'd0;
        FnReadRegister1 = 5'd0;
        FnReadRegister2 = 5'd0;
        FnWriteRegister = 5'd0;
        FnRegWrite      = 1'b1;
        #1 Reset = 1'b1;
        #2;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_pass", {31'd0, Pass}, 32'd0);
        check("rst_fail", {24'd0, FailAddr, FailPort, FailPattern}, 32'd0);
        check("rst_mux_we", {31'd0, RfRegWrite}, 32'd1);
        @(negedge Clk);
        Reset      = 1'b0;
        FnRegWrite = 1'b0;

        // Ideal file, functional write held active throughout the test,
        // plus a stray Start mid-test that must be ignored
        FnRegWrite      = 1'b1;
        FnWriteRegister = 5'd2;
        FnWriteData     = 32'd15;
        r = '{pass: 1'b1, addr: 5'd0, port: 1'b0, pat: 2'd0};
        run_bist(0, r, 1'b1);
        check("iso_we", {31'd0, RfRegWrite}, 32'd1);
        check("iso_wa", {27'd0, RfWriteRegister}, 32'd2);
        check("iso_wd", RfWriteData, 32'd15);
        FnReadRegister1 = 5'd2;
        FnReadRegister2 = 5'd2;
        @(negedge Clk);
        check("fn_rd1", FnReadData1, 32'd15);
        check("fn_rd2", FnReadData2, 32'd15);
        FnRegWrite = 1'b0;

        r = '{pass: 1'b0, addr: 5'd0, port: 1'b0, pat: 2'd0};
        run_bist(1, r, 1'b0);
        r = '{pass: 1'b0, addr: 5'd0, port: 1'b1, pat: 2'd0};
        run_bist(2, r, 1'b0);
        r = '{pass: 1'b0, addr: 5'd1, port: 1'b0, pat: 2'd2};
        run_bist(3, r, 1'b0);

        // Asynchronous reset in the middle of a test
        fault           = 0;
        FnRegWrite      = 1'b1;
        FnWriteRegister = 5'd7;
        FnWriteData     = 32'h1234;
        @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (50) @(negedge Clk);
        check("mid_busy_before", {31'd0, Busy}, 32'd1);
        #2 Reset = 1'b1;
        #1;
        check("mid_busy", {31'd0, Busy}, 32'd0);
        check("mid_done", {31'd0, Done}, 32'd0);
        check("mid_pass", {31'd0, Pass}, 32'd0);
        check("mid_we", {31'd0, RfRegWrite}, {31'd0, FnRegWrite});
        check("mid_wa", {27'd0, RfWriteRegister}, 32'd7);
        @(negedge Clk);
        Reset      = 1'b0;
        FnRegWrite = 1'b0;
        r = '{pass: 1'b1, addr: 5'd0, port: 1'b0, pat: 2'd0};
        run_bist(0, r, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_bist_ctrl.md
Name: regfile_bist_ctrl

Overview:
- Built-in self-test controller and port multiplexer for the 32x32 two-read/one-write register file.
- On `Start` it takes over all register-file ports and runs a three-pattern write/read-back march over every address on both read ports, then reports pass/fail with the first failing location.
- When idle, it passes the CPU's functional port signals straight through to the register file.

Parameters:
- PAT_A, 32'hAAAAAAAA, data pattern 0 (same value at every address)
- PAT_B, 32'h55555555, data pattern 1 (same value at every address)

Ports:
- Clk  in  1  clock; posedge active (register file also writes on posedge)
- Reset  in  1  asynchronous, active-high
- Start  in  1  begin self-test; sampled on posedge while IDLE
- Busy  out  1  high while BIST owns the register file
- Done  out  1  one-cycle pulse when the test completes
- Pass  out  1  test result; valid from Done until the next Start
- FailAddr  out  5  address of the first mismatch
- FailPort  out  1  port of the first mismatch: 0 = read port 1, 1 = read port 2
- FailPattern  out  2  pattern index (0..2) of the first mismatch
- FnWriteData  in  32  functional write data
- FnReadRegister1  in  5  functional read address, port 1
- FnReadRegister2  in  5  functional read address, port 2
- FnWriteRegister  in  5  functional write address
- FnRegWrite  in  1  functional write enable
- FnReadData1  out  32  equals RfReadData1, always
- FnReadData2  out  32  equals RfReadData2, always
- RfWriteData  out  32  to register file
- RfReadRegister1  out  5  to register file
- RfReadRegister2  out  5  to register file
- RfWriteRegister  out  5  to register file
- RfRegWrite  out  1  to register file
- RfReadData1  in  32  from register file; combinational read
- RfReadData2  in  32  from register file; combinational read

Behaviour:
- **Reset values:** state=IDLE, Busy=0, Done=0, Pass=0, FailAddr=0, FailPort=0, FailPattern=0, internal addr=0, pattern index p=0.
- **Port mux:** combinational. Busy=0 → Rf* outputs equal the matching Fn* inputs. Busy=1 → Rf* outputs are driven by the BIST and all Fn* inputs are ignored; a functional write during the test is dropped, not queued.
- **Data function:**
  - D(0,a)=PAT_A; D(1,a)=PAT_B.
  - D(2,a)={a,a,a,a,a,a,a[1:0]}, e.g. D(2,1)=32'h08421085, D(2,31)=32'hFFFFFFFF.
  - Expected read value E(p,a) = 0 if a==0, else D(p,a). Register 0 must read zero even after being written.
- **States:** IDLE → WRITE → READ → (next p: WRITE | last: DONE) → IDLE.
- **IDLE:** Start=1 at a posedge → WRITE, p=0, addr=0, Pass=1, Fail* cleared. Start in any other state is ignored.
- **WRITE (32 cycles, addr 0..31):** RfRegWrite=1, RfWriteRegister=addr, RfWriteData=D(p,addr). addr increments each edge; on addr==31 go to READ with addr=0.
- **READ (32 cycles):** RfRegWrite=0, RfReadRegister1=addr, RfReadRegister2=~addr (that is, 31-addr).
  - At each posedge compare RfReadData1 against E(p,addr) and RfReadData2 against E(p,~addr).
  - On the first mismatch since Start: Pass←0 and latch FailAddr, FailPort, FailPattern. FailAddr is the address presented on the failing port. If both ports mismatch, port 1 is recorded.
  - Later mismatches are ignored; the test always runs to completion.
  - On addr==31: if p<2 then p+1 and WRITE, else DONE.
- **DONE:** Busy=0, Done=1 for exactly one cycle, then IDLE.
- **Latency:** Start sampled at edge t0; Busy is high from t0 until t192 (3x64 cycles); Done is high between t192 and t193. Pass and Fail* are held stable until the next accepted Start.
- **Reset mid-test:** all state and outputs return to reset values immediately, without waiting for a clock. Busy=0, so the Rf* outputs switch to the Fn* inputs in the same delta and no partial BIST write is issued afterwards.
- **Addr counter:** wraps 31→0 only at phase boundaries; p never exceeds 2.

Test Plan:
- **Ideal register file:** Start pulse → Busy high for 192 cycles, Done pulse at t192, Pass=1, Fail*=0.
- **Register 0 implemented as a real register:** → Pass=0, FailAddr=0, FailPort=0, FailPattern=0 (port 1 reads 32'hAAAAAAAA where 0 is expected).
- **Port 2 stuck reading register 17:** → Pass=0, FailAddr=0, FailPort=1, FailPattern=0 (at READ addr 31, port 2 returns 32'hAAAAAAAA where 0 is expected).
- **Write decoder writes all registers (register 0 still hardwired to 0):** → patterns 0 and 1 pass; Pass=0, FailAddr=1, FailPort=0, FailPattern=2 (reads 32'hFFFFFFFF where 32'h08421085 is expected).
- **Functional isolation:**
  - During the test drive FnRegWrite=1, FnWriteRegister=2, FnWriteData=15 → RfRegWrite follows the BIST only, and Pass=1.
  - After Done, write 15 to register 2 functionally → FnReadData1/2 = 15 with both read addresses set to 2.
- **Reset mid-test:** assert Reset at cycle 50 after Start → Busy, Done and Pass drop to 0 immediately and RfRegWrite equals FnRegWrite. A new Start then completes with Pass=1.
